// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: event-mode encodings
// and the mode-to-event selection used by every channel.
package edge_det_pkg;

    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t MODE_OFF  = 2'b00;
    localparam edge_mode_t MODE_RISE = 2'b01;
    localparam edge_mode_t MODE_FALL = 2'b10;
    localparam edge_mode_t MODE_BOTH = 2'b11;

    // Bit 0 enables rising edges, bit 1 enables falling edges.
    function automatic logic evt_select(input edge_mode_t m, input logic pos, input logic neg);
        return (m[0] & pos) | (m[1] & neg);
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One channel: synchroniser, optional debounce (EDGE_DEBOUNCE_EN), rise/fall
// detection, mode-selected event, wrapping event counter and sticky flags.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  edge_mode_t       mode,
    input  logic             clr,
    output logic             pos_edge,
    output logic             neg_edge,
    output logic             evt,
    output logic             evt_sticky,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_ovf
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || CNT_W < 2) begin : g_param_check
        $error("edge_det_chan: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_last;
    logic                   flt_reg;
    logic                   flt_d_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   ovf_reg;
    logic                   sticky_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pulse_in};
        end
    end

    assign s_last = sync_reg[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 1);

    logic [DW-1:0] dcnt_reg;

    // A new level must be seen DEBOUNCE_CYC cycles in a row; any return to
    // the accepted level restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_reg  <= 1'b0;
            dcnt_reg <= '0;
        end else if (s_last == flt_reg) begin
            dcnt_reg <= '0;
        end else if (dcnt_reg == DCNT_LAST) begin
            flt_reg  <= s_last;
            dcnt_reg <= '0;
        end else begin
            dcnt_reg <= dcnt_reg + DW'(1);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_reg <= 1'b0;
        end else begin
            flt_reg <= s_last;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_d_reg <= 1'b0;
        end else begin
            flt_d_reg <= flt_reg;
        end
    end

    assign pos_edge = flt_reg & ~flt_d_reg;
    assign neg_edge = ~flt_reg & flt_d_reg;
    assign evt      = evt_select(mode, pos_edge, neg_edge);

    // A clear coinciding with an event restarts the count at 1 so the event survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            ovf_reg    <= 1'b0;
            sticky_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg    <= {{(CNT_W-1){1'b0}}, evt};
            ovf_reg    <= 1'b0;
            sticky_reg <= evt;
        end else if (evt) begin
            cnt_reg    <= cnt_reg + CNT_W'(1);
            sticky_reg <= 1'b1;
            if (&cnt_reg) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign edge_cnt   = cnt_reg;
    assign cnt_ovf    = ovf_reg;
    assign evt_sticky = sticky_reg;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: CH independent edge_det_chan instances with
// packed per-channel ports. Debounce is built only when EDGE_DEBOUNCE_EN is defined.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int CH           = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       pulse_in,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       pos_edge,
    output logic [CH-1:0]       neg_edge,
    output logic [CH-1:0]       evt,
    output logic [CH-1:0]       evt_sticky,
    output logic [CNT_W*CH-1:0] edge_cnt,
    output logic [CH-1:0]       cnt_ovf
);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_chan
            edge_det_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEBOUNCE_CYC(DEBOUNCE_CYC),
                .CNT_W       (CNT_W)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .pulse_in  (pulse_in[gi]),
                .mode      (edge_mode_t'(mode[2*gi +: 2])),
                .clr       (clr[gi]),
                .pos_edge  (pos_edge[gi]),
                .neg_edge  (neg_edge[gi]),
                .evt       (evt[gi]),
                .evt_sticky(evt_sticky[gi]),
                .edge_cnt  (edge_cnt[CNT_W*gi +: CNT_W]),
                .cnt_ovf   (cnt_ovf[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_edge_detector.sv
// Scoreboard bench for multi_edge_detector: stimulus pushes expected edge events,
// a negedge monitor pops and compares them; register state is checked directly.
module tb_multi_edge_detector;

    localparam int CH = 4;
    localparam int CW = 8;
`ifdef EDGE_DEBOUNCE_EN
    localparam int DB  = 4;
    localparam int LAT = 5;
`else
    localparam int DB  = 1;
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     pulse_in = '0;
    logic [2*CH-1:0]   mode = '0;
    logic [CH-1:0]     clr = '0;
    logic [CH-1:0]     pos_edge, neg_edge, evt, evt_sticky, cnt_ovf;
    logic [CW*CH-1:0]  edge_cnt;

    multi_edge_detector #(
        .CH(CH), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .mode(mode), .clr(clr),
        .pos_edge(pos_edge), .neg_edge(neg_edge), .evt(evt),
        .evt_sticky(evt_sticky), .edge_cnt(edge_cnt), .cnt_ovf(cnt_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       at;
        logic [3:0] pos;
        logic [3:0] neg;
        logic [3:0] ev;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp1 = 0;

    task automatic push(input int at, input logic [3:0] p, input logic [3:0] n, input logic [3:0] e);
        exp_t x;
        x.at = at; x.pos = p; x.neg = n; x.ev = e;
        sb.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
        end else begin
            $display("ok   %s = %0h (cyc %0d)", name, got, cyc);
        end
    endtask

    function automatic logic [7:0] cnt(input int c);
        return edge_cnt[c*CW +: CW];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the masked channels to lvl and expect the matching edge LAT cycles after edge 0.
    task automatic set_lvl(input logic [3:0] mask, input logic lvl, input logic [3:0] emask);
        for (int c = 0; c < CH; c++) if (mask[c]) pulse_in[c] = lvl;
        push(cyc + 1 + LAT, lvl ? mask : 4'b0, lvl ? 4'b0 : mask, emask);
    endtask

    task automatic pulse_ch1(input int w);
        if (w >= DB) begin
            push(cyc + 1 + LAT, 4'b0010, 4'b0000, 4'b0010);
            push(cyc + 1 + w + LAT, 4'b0000, 4'b0010, 4'b0010);
            exp1 += 2;
        end
        pulse_in[1] = 1'b1;
        tick(w);
        pulse_in[1] = 1'b0;
        tick(w + LAT + 4);
        chk($sformatf("pulse_w%0d_cnt1", w), cnt(1), exp1);
    endtask

    // Monitor: every cycle with any edge/event output must match the queue head.
    always @(negedge clk) begin
        if (rst_n && ((pos_edge | neg_edge | evt) != 4'b0)) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_edge cyc=%0d pos=%b neg=%b evt=%b", cyc, pos_edge, neg_edge, evt);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.at != cyc || mon_e.pos != pos_edge || mon_e.neg != neg_edge || mon_e.ev != evt) begin
                    n_fail++;
                    $display("FAIL edge_event got cyc=%0d pos=%b neg=%b evt=%b exp cyc=%0d pos=%b neg=%b evt=%b",
                             cyc, pos_edge, neg_edge, evt, mon_e.at, mon_e.pos, mon_e.neg, mon_e.ev);
                end else begin
                    $display("ok   edge_event cyc=%0d pos=%b neg=%b evt=%b", cyc, pos_edge, neg_edge, evt);
                end
            end
        end
    end

    initial begin
        // Reset with all inputs high: ch0 rise, ch1 both, ch2 fall, ch3 off.
        mode     = {2'b00, 2'b10, 2'b11, 2'b01};
        pulse_in = 4'hF;
        rst_n    = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("reset_flags", {pos_edge, neg_edge, evt, evt_sticky, cnt_ovf}, 0);
            chk("reset_cnt", edge_cnt, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(cyc + 1 + LAT, 4'hF, 4'h0, 4'b0011);
        tick(LAT + 4);
        chk("rel_cnt0", cnt(0), 1);
        chk("rel_cnt1", cnt(1), 1);
        chk("rel_cnt2", cnt(2), 0);
        chk("rel_cnt3", cnt(3), 0);
        chk("rel_sticky", evt_sticky, 4'b0011);
        set_lvl(4'hF, 1'b0, 4'b0110);
        tick(LAT + 4);
        chk("fall_cnt1", cnt(1), 2);
        chk("fall_cnt2", cnt(2), 1);
        chk("fall_ovf", cnt_ovf, 0);
        clr = 4'hF;
        tick(1);
        clr = 4'h0;
        chk("clr_cnt", edge_cnt, 0);
        chk("clr_sticky", evt_sticky, 0);

        // Latency on ch0 in rise mode.
        set_lvl(4'b0001, 1'b1, 4'b0001);
        tick(LAT + 3);
        chk("lat_cnt0", cnt(0), 1);
        chk("lat_sticky0", evt_sticky[0], 1);
        set_lvl(4'b0001, 1'b0, 4'b0000);
        tick(LAT + 3);
        chk("lat_fall_cnt0", cnt(0), 1);

        // Pulse-width filtering on ch1 in both mode.
        pulse_ch1(3);
        pulse_ch1(4);
        pulse_ch1(1);

        // Mode off on ch0: edges still pulse, no events counted.
        clr[0] = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        mode[1:0] = 2'b00;
        set_lvl(4'b0001, 1'b1, 4'b0000);
        tick(LAT + 3);
        set_lvl(4'b0001, 1'b0, 4'b0000);
        tick(LAT + 3);
        chk("off_cnt0", cnt(0), 0);
        chk("off_sticky0", evt_sticky[0], 0);

        // Wrap: ch2 gets 300 edges, ch3 the first 263 (leaves cnt 7 with overflow).
        mode[7:4] = 4'hF;
        for (int i = 1; i <= 300; i++) begin
            logic [3:0] m;
            m = (i <= 263) ? 4'b1100 : 4'b0100;
            set_lvl(m, (i % 2) == 1, m);
            tick(10);
            if (i == 255) begin
                chk("wrap255_cnt2", cnt(2), 255);
                chk("wrap255_ovf2", cnt_ovf[2], 0);
            end
            if (i == 256) begin
                chk("wrap256_cnt2", cnt(2), 0);
                chk("wrap256_ovf2", cnt_ovf[2], 1);
            end
            if (i == 263) begin
                chk("pre_clr_cnt3", cnt(3), 7);
                chk("pre_clr_ovf3", cnt_ovf[3], 1);
            end
        end
        chk("wrap_final_cnt2", cnt(2), 44);
        chk("wrap_final_ovf2", cnt_ovf[2], 1);

        // Clear landing on the same cycle as an event on ch3.
        set_lvl(4'b1000, 1'b0, 4'b1000);
        tick(LAT + 1);
        clr[3] = 1'b1;
        tick(1);
        clr[3] = 1'b0;
        chk("coll_cnt3", cnt(3), 1);
        chk("coll_ovf3", cnt_ovf[3], 0);
        chk("coll_sticky3", evt_sticky[3], 1);
        clr[3] = 1'b1;
        tick(1);
        clr[3] = 1'b0;
        chk("clr_only_cnt3", cnt(3), 0);
        chk("clr_only_sticky3", evt_sticky[3], 0);

        tick(20);
        chk("sb_drained", sb.size(), 0);

        // Asynchronous reset in the middle of a cycle clears everything at once.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cnt", edge_cnt, 0);
        chk("midrst_flags", {pos_edge, neg_edge, evt, evt_sticky, cnt_ovf}, 0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
